// File: rtl/d16_fetch_pkg.sv
// Shared definitions for the d16 instruction fetch sequencer.
package d16_fetch_pkg;

    localparam int unsigned D16_AW = 16;
    localparam int unsigned D16_DW = 16;
    localparam logic [15:0] D16_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        D16_FETCH_IDLE = 2'd0,
        D16_FETCH_REQ  = 2'd1,
        D16_FETCH_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/d16_fetch_fifo.sv
// Small shift-register fetch queue; the head lives in entry 0 so head/head_valid come straight from flops.
module d16_fetch_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            clr,
    input  logic [W-1:0]                    din,
    output logic [$clog2(DEPTH+1)-1:0]      count_c,
    output logic [W-1:0]                    head,
    output logic                            head_valid
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic                    pop_eff;
    logic [CW-1:0]           wr_idx;

    // Valid entries are always contiguous from slot 0.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_c = count_c + CW'(vld_q[i]);
        end
    end

    assign pop_eff = pop & vld_q[0];
    assign wr_idx  = count_c - CW'(pop_eff);

    // Clear wins; otherwise shift out the head first, then append at the freed tail.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end else begin
            if (pop_eff) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end
                vld_d[DEPTH-1] = 1'b0;
            end
            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == wr_idx) begin
                        mem_d[i] = din;
                        vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            vld_q <= '0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
        end
    end

    assign head       = mem_q[0];
    assign head_valid = vld_q[0];

endmodule

// File: rtl/d16_fetch.sv
// d16 instruction fetch sequencer: owns the fetch PC, one outstanding bus read, redirect/flush handling.
module d16_fetch
    import d16_fetch_pkg::*;
#(
    parameter int unsigned    AW       = D16_AW,
    parameter int unsigned    DW       = D16_DW,
    parameter logic [AW-1:0]  RESET_PC = AW'(D16_RESET_PC),
    parameter int unsigned    DEPTH    = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          jmp_load,
    input  logic [AW-1:0] jmp_addr,
    output logic [AW-1:0] im_addr,
    output logic          im_req,
    input  logic          im_ack,
    input  logic [DW-1:0] im_data,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic          flush
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [AW-1:0]    fpc_q, fpc_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             req_q;
    logic             flush_q;

    logic             push_c;
    logic             pop_c;
    logic [CW-1:0]    count_c;
    logic [CW-1:0]    cnt_after_pop_c;
    logic             room_c;
    logic [AW+DW-1:0] head_c;

    assign pop_c           = ir_valid & ir_ready;
    assign cnt_after_pop_c = count_c - CW'(pop_c);
    assign room_c          = cnt_after_pop_c < CW'(DEPTH);

    // Next-state, next fetch PC and next bus address.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        push_c  = 1'b0;
        unique case (state_q)
            D16_FETCH_IDLE: begin
                if (jmp_load) begin
                    fpc_d   = jmp_addr;
                    addr_d  = jmp_addr;
                    state_d = D16_FETCH_REQ;
                end else if (room_c) begin
                    addr_d  = fpc_q;
                    state_d = D16_FETCH_REQ;
                end
            end
            D16_FETCH_REQ: begin
                if (jmp_load) begin
                    fpc_d = jmp_addr;
                    if (im_ack) begin
                        addr_d = jmp_addr;
                    end else begin
                        state_d = D16_FETCH_DROP;
                    end
                end else if (im_ack) begin
                    push_c  = 1'b1;
                    fpc_d   = fpc_q + AW'(1);
                    addr_d  = fpc_q + AW'(1);
                    state_d = (cnt_after_pop_c < CW'(DEPTH - 1)) ? D16_FETCH_REQ : D16_FETCH_IDLE;
                end
            end
            D16_FETCH_DROP: begin
                if (jmp_load) begin
                    fpc_d = jmp_addr;
                end
                if (im_ack) begin
                    addr_d  = jmp_load ? jmp_addr : fpc_q;
                    state_d = D16_FETCH_REQ;
                end
            end
            default: state_d = D16_FETCH_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= D16_FETCH_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= (state_d != D16_FETCH_IDLE);
            flush_q <= jmp_load;
        end
    end

    d16_fetch_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .push       (push_c),
        .pop        (pop_c),
        .clr        (jmp_load),
        .din        ({fpc_q, im_data}),
        .count_c    (count_c),
        .head       (head_c),
        .head_valid (ir_valid)
    );

    assign im_addr = addr_q;
    assign im_req  = req_q;
    assign flush   = flush_q;
    assign ir      = head_c[DW-1:0];
    assign ir_pc   = head_c[AW+DW-1:DW];

endmodule

// File: tb/tb_d16_fetch.sv
// Directed bench for d16_fetch with hand-computed expectations.
module tb_d16_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        jmp_load;
    logic [15:0] jmp_addr;
    logic [15:0] im_addr;
    logic        im_req;
    logic        im_ack;
    logic [15:0] im_data;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    d16_fetch dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .jmp_load (jmp_load),
        .jmp_addr (jmp_addr),
        .im_addr  (im_addr),
        .im_req   (im_req),
        .im_ack   (im_ack),
        .im_data  (im_data),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .flush    (flush)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(im_req),   32'h0);
        chk({tag, "_addr"},  32'(im_addr),  32'h0);
        chk({tag, "_ir"},    32'(ir),       32'h0);
        chk({tag, "_irpc"},  32'(ir_pc),    32'h0);
        chk({tag, "_valid"}, 32'(ir_valid), 32'h0);
        chk({tag, "_flush"}, 32'(flush),    32'h0);
    endtask

    initial begin
        sys_rst  = 1'b1;
        jmp_load = 1'b0;
        jmp_addr = '0;
        im_ack   = 1'b0;
        im_data  = '0;
        ir_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");

        // 1: first request after release, first word lands one cycle after ack
        sys_rst = 1'b0;
        tick();
        chk("t1_req", 32'(im_req), 32'h1);
        chk("t1_addr", 32'(im_addr), 32'h0);
        chk("t1_valid_pre", 32'(ir_valid), 32'h0);
        im_ack  = 1'b1;
        im_data = 16'h1234;
        tick();
        chk("t1_ir", 32'(ir), 32'h1234);
        chk("t1_irpc", 32'(ir_pc), 32'h0);
        chk("t1_valid", 32'(ir_valid), 32'h1);
        chk("t1_addr_next", 32'(im_addr), 32'h1);

        // 2: streaming, one word per cycle with decode consuming
        ir_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            im_data = 16'h1000 + 16'(i);
            tick();
            chk("t2_addr", 32'(im_addr), 32'(i + 1));
            chk("t2_irpc", 32'(ir_pc), 32'(i));
            chk("t2_ir", 32'(ir), 32'h1000 + 32'(i));
            chk("t2_req", 32'(im_req), 32'h1);
        end

        // 3: drain, then stall decode: two pushes fill the queue and stop requests
        im_ack = 1'b0;
        tick();
        chk("t3_empty", 32'(ir_valid), 32'h0);
        chk("t3_addr_hold", 32'(im_addr), 32'h4);
        tick();
        chk("t3_pop_empty", 32'(ir_valid), 32'h0);
        ir_ready = 1'b0;
        im_ack   = 1'b1;
        im_data  = 16'h2004;
        tick();
        chk("t3_req1", 32'(im_req), 32'h1);
        chk("t3_addr1", 32'(im_addr), 32'h5);
        im_data = 16'h2005;
        tick();
        chk("t3_req_full", 32'(im_req), 32'h0);
        chk("t3_head", 32'(ir_pc), 32'h4);
        im_ack = 1'b0;
        tick();
        chk("t3_req_stay", 32'(im_req), 32'h0);
        ir_ready = 1'b1;
        tick();
        chk("t3_req_resume", 32'(im_req), 32'h1);
        chk("t3_addr_resume", 32'(im_addr), 32'h6);
        chk("t3_ir_next", 32'(ir), 32'h2005);
        ir_ready = 1'b0;

        // 4: redirect with no same-cycle ack, stale word dropped
        jmp_load = 1'b1;
        jmp_addr = 16'h0040;
        tick();
        chk("t4_flush", 32'(flush), 32'h1);
        chk("t4_valid_drop", 32'(ir_valid), 32'h0);
        chk("t4_addr_hold", 32'(im_addr), 32'h6);
        chk("t4_req_hold", 32'(im_req), 32'h1);
        jmp_load = 1'b0;
        tick();
        chk("t4_flush_once", 32'(flush), 32'h0);
        chk("t4_addr_hold2", 32'(im_addr), 32'h6);
        im_ack  = 1'b1;
        im_data = 16'hDEAD;
        tick();
        chk("t4_addr_tgt", 32'(im_addr), 32'h0040);
        chk("t4_stale", 32'(ir_valid), 32'h0);
        im_data = 16'h4040;
        tick();
        chk("t4_valid", 32'(ir_valid), 32'h1);
        chk("t4_ir", 32'(ir), 32'h4040);
        chk("t4_irpc", 32'(ir_pc), 32'h0040);
        chk("t4_addr_next", 32'(im_addr), 32'h0041);

        // 5: redirect coinciding with ack, target at top of address space
        jmp_load = 1'b1;
        jmp_addr = 16'hFFFF;
        im_data  = 16'hBEEF;
        tick();
        chk("t5_addr", 32'(im_addr), 32'hFFFF);
        chk("t5_req", 32'(im_req), 32'h1);
        chk("t5_valid", 32'(ir_valid), 32'h0);
        chk("t5_flush", 32'(flush), 32'h1);
        jmp_load = 1'b0;
        im_data  = 16'h5FFF;
        tick();
        chk("t5_wrap", 32'(im_addr), 32'h0000);
        chk("t5_irpc", 32'(ir_pc), 32'hFFFF);
        chk("t5_ir", 32'(ir), 32'h5FFF);
        chk("t5_flush_off", 32'(flush), 32'h0);
        ir_ready = 1'b1;
        im_data  = 16'h5000;
        tick();
        chk("t5_irpc0", 32'(ir_pc), 32'h0000);
        chk("t5_ir0", 32'(ir), 32'h5000);
        chk("t5_addr1", 32'(im_addr), 32'h0001);
        im_ack   = 1'b0;
        ir_ready = 1'b0;

        // 6: async reset mid-transaction, ack around reset ignored
        sys_rst = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        im_ack  = 1'b1;
        im_data = 16'h6666;
        tick();
        chk_reset_vals("t6_hold");
        sys_rst = 1'b0;
        tick();
        chk("t6_req", 32'(im_req), 32'h1);
        chk("t6_addr", 32'(im_addr), 32'h0);
        chk("t6_stale", 32'(ir_valid), 32'h0);
        im_ack = 1'b0;
        tick();
        chk("t6_wait", 32'(ir_valid), 32'h0);
        im_ack  = 1'b1;
        im_data = 16'h7000;
        tick();
        chk("t6_ir", 32'(ir), 32'h7000);
        chk("t6_irpc", 32'(ir_pc), 32'h0);
        chk("t6_valid", 32'(ir_valid), 32'h1);
        im_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
